user_stream_scheduler: RTL and testbench
========================================

# user_stream_scheduler

Shares one user-clock processing engine (e.g. the emboss kernel) between the four host stream channels. It sits between the stream adapter's user-side ports and a single-instance engine. The forward path is arbitrated round-robin in bursts and each beat is tagged with its channel. Tagged engine results are steered back to the originating channel's return stream through a one-entry output register per channel.

## Interface
- `NCH`, 4: stream channel count (fixed 4; tag width 2).
- `DW`, 64: stream data width.
- `BURST_LEN`, 16: beats granted per arbitration win (≥1).
- `IDLE_MAX`, 8: consecutive idle cycles inside a burst before the grant is dropped early (≥1).
- `i_user_clk`  in  1: sole clock.
- `i_rst`  in  1: synchronous, active-low reset.
- `i_chan_en`  in  4: per-channel enable, from the register interface; sampled only at arbitration.
- `i_str_data_valid`  in  4: per-channel forward valid from the adapter.
- `o_str_ack`  out  4: per-channel forward ack.
- `i_str_data`  in  4*DW: channel k occupies bits [k*DW +: DW].
- `o_eng_data_valid`  out  1: beat to the engine.
- `i_eng_ack`  in  1: engine accepts the beat.
- `o_eng_data`  out  DW: beat data to the engine.
- `o_eng_tag`  out  2: source channel of the beat.
- `i_eng_res_valid`  in  1: engine result valid.
- `o_eng_res_ack`  out  1: result accepted.
- `i_eng_res_data`  in  DW: result data.
- `i_eng_res_tag`  in  2: destination channel of the result.
- `o_str_data_valid`  out  4: per-channel return valid to the adapter.
- `i_str_ack`  in  4: per-channel return ack.
- `o_str_data`  out  4*DW: per-channel return data.
- `o_grant`  out  4: one-hot current grant (status).
- `o_busy`  out  1: high whenever the state is not IDLE.

## Operation
- Handshake on every interface: transfer occurs in the cycle where valid && ack are both high. Valid must not depend on ack.
- FSM states: IDLE, BURST.
- IDLE:
  - Candidates = `i_str_data_valid & i_chan_en`.
  - Select the first candidate strictly after `last_grant`, wrapping 3→0.
  - If any candidate exists: load `grant`, clear `beat_cnt` and `idle_cnt`, go to BURST, set `last_grant`.
- BURST:
  - `o_eng_data_valid = i_str_data_valid[grant]`, `o_eng_data`/`o_eng_tag` are muxed from `grant`, and `o_str_ack[grant] = i_eng_ack`. All other `o_str_ack` are 0.
  - On each transfer: `beat_cnt++` and clear `idle_cnt`.
  - Cycles with `i_str_data_valid[grant]` low: `idle_cnt++`.
  - Return to IDLE on the transfer that makes `beat_cnt == BURST_LEN`, or when `idle_cnt` reaches `IDLE_MAX`.
  - The engine stalling (valid high, ack low) does not count as idle.
- Clearing `i_chan_en[grant]` mid-burst does not truncate the burst.
- Return path:
  - Each channel k has a one-entry register (valid/data).
  - `o_eng_res_ack = !ret_valid[tag] || i_str_ack[tag]`, so the register accepts a result when it is empty or draining in the same cycle.
  - A result for a full, stalled channel blocks every channel (head-of-line blocking); this is intentional.
- Counter widths: `beat_cnt` is `clog2(BURST_LEN+1)` bits and `idle_cnt` is `clog2(IDLE_MAX+1)` bits, with no wrap.

## Timing
- Reset values: state IDLE, `grant`/`o_grant` = 0, `last_grant` = 3 (so channel 0 wins first), all counters 0, `o_busy` = 0, all `o_str_ack` = 0, `o_eng_data_valid` = 0, all `o_str_data_valid` = 0, `o_str_data` = 0.
- Arbitration costs one cycle: a request seen in IDLE produces its first possible forward transfer on the next cycle. BURST→IDLE→BURST therefore leaves one bubble cycle.
- The forward path is combinational (zero latency): valid, data and tag flow through the mux and ack flows back to the source.
- The return path has one-cycle latency: a result accepted at edge n appears on `o_str_data_valid[tag]` after edge n.
- If a result is loaded into channel k's register in the same cycle that channel k drains, the register stays valid with the new data and there is no bubble.
- Reset asserted mid-burst or with data held: everything returns to reset values at the next edge. In-flight beats are dropped; the host re-issues them.

## Structure
- Shared package `stream_sched_pkg`: the FSM state enum, the `NCH` and tag-width constants, and a round-robin next-grant function.
- One sub-module, `stream_ret_slot`: the per-channel one-entry return register, instantiated `NCH` times.

## Test plan
- Single channel: reset, enable=4'b0001, channel 0 sends 40 beats with the engine always acking. Expected: bursts of 16+16+8, one-cycle gaps, all tags 0, with 40 results looped back in order on `o_str_data_valid[0]`.
- Fairness: all four channels continuously valid with `BURST_LEN`=16. Expected: grant order 0,1,2,3,0…, each burst exactly 16 beats, `o_grant` one-hot.
- Idle drop: channel 2 sends 5 beats then deasserts valid while channel 3 is waiting. Expected: grant released after 8 idle cycles, then channel 3 granted.
- Enable mask: `i_chan_en`=4'b1010 with all channels valid. Expected: only channels 1 and 3 are granted, and `o_str_ack[0]`/`o_str_ack[2]` never assert.
- Return backpressure: hold `i_str_ack[1]`=0 with two results tagged 1. Expected: the first is held in the register and `o_eng_res_ack` drops for the second. Release the ack and both are delivered in consecutive cycles.
- Reset mid-burst: assert `i_rst`=0 at beat 7 of a burst. Expected: next edge shows `o_busy`=0, all acks and valids 0, and after release channel 0 wins first.

Source files
------------

// File: rtl/stream_sched_pkg.sv
// Shared types for the user-clock stream scheduler: FSM states, channel/tag sizing
// and the round-robin grant picker.
package stream_sched_pkg;

    localparam int NCH = 4;
    localparam int TW  = $clog2(NCH);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // First requester strictly after 'last', wrapping; nearest distance is scanned
    // last so it overrides farther ones. Caller guarantees req is non-zero.
    function automatic logic [TW-1:0] rr_next(input logic [NCH-1:0] req,
                                              input logic [TW-1:0]  last);
        logic [TW-1:0] sel;
        logic [TW-1:0] idx;
        sel = last;
        for (int i = NCH; i >= 1; i--) begin
            idx = last + TW'(i);
            if (req[idx]) sel = idx;
        end
        return sel;
    endfunction

endpackage

// File: rtl/stream_ret_slot.sv
// One-entry return register for a single channel; one cycle load-to-valid, a load
// in the same cycle as a drain keeps it full; the upstream stalls while it is full.
module stream_ret_slot #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          ack,
    output logic          valid,
    output logic [DW-1:0] data
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ack) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/user_stream_scheduler.sv
// Shares one engine among four stream channels: round-robin bursts forward (zero latency,
// one arbitration cycle), tagged results back via per-channel one-entry slots (HOL blocking).
module user_stream_scheduler
    import stream_sched_pkg::*;
#(
    parameter int DW        = 64,
    parameter int BURST_LEN = 16,
    parameter int IDLE_MAX  = 8
) (
    input  logic              i_user_clk,
    input  logic              i_rst,
    input  logic [NCH-1:0]    i_chan_en,
    input  logic [NCH-1:0]    i_str_data_valid,
    output logic [NCH-1:0]    o_str_ack,
    input  logic [NCH*DW-1:0] i_str_data,
    output logic              o_eng_data_valid,
    input  logic              i_eng_ack,
    output logic [DW-1:0]     o_eng_data,
    output logic [TW-1:0]     o_eng_tag,
    input  logic              i_eng_res_valid,
    output logic              o_eng_res_ack,
    input  logic [DW-1:0]     i_eng_res_data,
    input  logic [TW-1:0]     i_eng_res_tag,
    output logic [NCH-1:0]    o_str_data_valid,
    input  logic [NCH-1:0]    i_str_ack,
    output logic [NCH*DW-1:0] o_str_data,
    output logic [NCH-1:0]    o_grant,
    output logic              o_busy
);

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int IW = $clog2(IDLE_MAX + 1);

    state_t         state;
    logic [TW-1:0]  grant;
    logic [TW-1:0]  last_grant;
    logic [BW-1:0]  beat_cnt;
    logic [IW-1:0]  idle_cnt;
    logic [NCH-1:0] cand;
    logic [TW-1:0]  next_grant;
    logic           fwd_vld;
    logic           fwd_xfer;
    logic           drop;
    logic [NCH-1:0] ret_vld;
    logic [NCH-1:0] ret_load;

    assign cand       = i_str_data_valid & i_chan_en;
    assign next_grant = rr_next(cand, last_grant);
    assign fwd_vld    = (state == BURST) && i_str_data_valid[grant];
    assign fwd_xfer   = fwd_vld && i_eng_ack;

    // A stalled engine (valid high, ack low) neither advances nor counts as idle.
    assign drop = fwd_xfer ? (beat_cnt == BW'(BURST_LEN - 1))
                           : (!i_str_data_valid[grant] && idle_cnt == IW'(IDLE_MAX - 1));

    always_ff @(posedge i_user_clk) begin
        if (!i_rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= TW'(NCH - 1);
            beat_cnt   <= '0;
            idle_cnt   <= '0;
            o_grant    <= '0;
            o_busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|cand) begin
                        state      <= BURST;
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        beat_cnt   <= '0;
                        idle_cnt   <= '0;
                        o_grant    <= NCH'(1) << next_grant;
                        o_busy     <= 1'b1;
                    end
                end
                BURST: begin
                    if (fwd_xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        idle_cnt <= '0;
                    end else if (!i_str_data_valid[grant]) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                    if (drop) begin
                        state   <= IDLE;
                        o_grant <= '0;
                        o_busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_eng_data_valid = fwd_vld;
    assign o_eng_data       = i_str_data[grant*DW +: DW];
    assign o_eng_tag        = grant;

    always_comb begin
        o_str_ack = '0;
        if (state == BURST) o_str_ack[grant] = i_eng_ack;
    end

    assign o_eng_res_ack    = !ret_vld[i_eng_res_tag] || i_str_ack[i_eng_res_tag];
    assign o_str_data_valid = ret_vld;

    for (genvar k = 0; k < NCH; k++) begin : g_ret
        assign ret_load[k] = i_eng_res_valid && o_eng_res_ack && (i_eng_res_tag == TW'(k));

        stream_ret_slot #(.DW(DW)) u_slot (
            .clk       (i_user_clk),
            .rst       (i_rst),
            .load      (ret_load[k]),
            .load_data (i_eng_res_data),
            .ack       (i_str_ack[k]),
            .valid     (ret_vld[k]),
            .data      (o_str_data[k*DW +: DW])
        );
    end

endmodule

// File: tb/tb_user_stream_scheduler.sv
// Randomized scoreboard bench: sources push expected beats/results on issue, a negedge
// monitor pops on every DUT transfer and checks control outputs against a cycle model.
module tb_user_stream_scheduler;

    localparam int          DW   = 64;
    localparam int          BL   = 16;
    localparam int          IM   = 8;
    localparam logic [63:0] MASK = 64'h5A5A_0F0F_C3C3_9696;

    logic            i_user_clk = 1'b0;
    logic            i_rst;
    logic [3:0]      i_chan_en;
    logic [3:0]      i_str_data_valid;
    logic [3:0]      o_str_ack;
    logic [4*DW-1:0] i_str_data;
    logic            o_eng_data_valid;
    logic            i_eng_ack;
    logic [DW-1:0]   o_eng_data;
    logic [1:0]      o_eng_tag;
    logic            i_eng_res_valid;
    logic            o_eng_res_ack;
    logic [DW-1:0]   i_eng_res_data;
    logic [1:0]      i_eng_res_tag;
    logic [3:0]      o_str_data_valid;
    logic [3:0]      i_str_ack;
    logic [4*DW-1:0] o_str_data;
    logic [3:0]      o_grant;
    logic            o_busy;

    always #5 i_user_clk = ~i_user_clk;

    user_stream_scheduler #(.DW(DW), .BURST_LEN(BL), .IDLE_MAX(IM)) dut (
        .i_user_clk       (i_user_clk),
        .i_rst            (i_rst),
        .i_chan_en        (i_chan_en),
        .i_str_data_valid (i_str_data_valid),
        .o_str_ack        (o_str_ack),
        .i_str_data       (i_str_data),
        .o_eng_data_valid (o_eng_data_valid),
        .i_eng_ack        (i_eng_ack),
        .o_eng_data       (o_eng_data),
        .o_eng_tag        (o_eng_tag),
        .i_eng_res_valid  (i_eng_res_valid),
        .o_eng_res_ack    (o_eng_res_ack),
        .i_eng_res_data   (i_eng_res_data),
        .i_eng_res_tag    (i_eng_res_tag),
        .o_str_data_valid (o_str_data_valid),
        .i_str_ack        (i_str_ack),
        .o_str_data       (o_str_data),
        .o_grant          (o_grant),
        .o_busy           (o_busy)
    );

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    logic [DW-1:0]   exp_fwd [4][$];
    logic [DW-1:0]   exp_ret [4][$];
    logic [DW+1:0]   eng_pipe[$];

    // Reference model: owner channel (-1 = none), last winner, burst/idle counts, return slots.
    int      m_owner = -1;
    int      m_last  = 3;
    int      m_beats = 0;
    int      m_idles = 0;
    bit [3:0] m_ret  = 4'h0;

    bit [3:0]      vld;
    logic [DW-1:0] sdat[4];
    int            rem[4];
    bit            res_hold;
    int            ph_x;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge i_user_clk) begin
        if (mon_en) begin
            logic [3:0] eg;
            logic [3:0] esa;
            logic       ev;
            logic       era;
            int         t;
            bit         found;
            eg  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'h0;
            ev  = (m_owner >= 0) && i_str_data_valid[m_owner];
            esa = (m_owner >= 0 && i_eng_ack) ? eg : 4'h0;
            era = !m_ret[i_eng_res_tag] || i_str_ack[i_eng_res_tag];
            chk("busy", 64'(o_busy), 64'(m_owner >= 0));
            chk("grant", 64'(o_grant), 64'(eg));
            chk("eng_valid", 64'(o_eng_data_valid), 64'(ev));
            chk("str_ack", 64'(o_str_ack), 64'(esa));
            chk("res_ack", 64'(o_eng_res_ack), 64'(era));
            chk("ret_valid", 64'(o_str_data_valid), 64'(m_ret));
            if (ev) chk("eng_tag", 64'(o_eng_tag), 64'(m_owner));
            if (o_eng_data_valid && i_eng_ack) begin
                t = int'(o_eng_tag);
                if (exp_fwd[t].size() == 0) begin
                    total++; bad++;
                    $display("FAIL fwd_extra: got beat on tag %0d, want none queued", t);
                end else begin
                    chk("fwd_data", o_eng_data, exp_fwd[t].pop_front());
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (o_str_data_valid[k] && i_str_ack[k]) begin
                    if (exp_ret[k].size() == 0) begin
                        total++; bad++;
                        $display("FAIL ret_extra: got result on ch %0d, want none queued", k);
                    end else begin
                        chk("ret_data", o_str_data[k*DW +: DW], exp_ret[k].pop_front());
                    end
                end
            end
            if (!i_rst) begin
                m_owner = -1; m_last = 3; m_beats = 0; m_idles = 0; m_ret = 4'h0;
            end else begin
                for (int k = 0; k < 4; k++)
                    if (m_ret[k] && i_str_ack[k]) m_ret[k] = 1'b0;
                if (i_eng_res_valid && era) m_ret[i_eng_res_tag] = 1'b1;
                if (m_owner < 0) begin
                    found = 1'b0;
                    for (int d = 1; d <= 4; d++) begin
                        t = (m_last + d) % 4;
                        if (!found && i_str_data_valid[t] && i_chan_en[t]) begin
                            found = 1'b1; m_owner = t; m_last = t; m_beats = 0; m_idles = 0;
                        end
                    end
                end else if (i_str_data_valid[m_owner] && i_eng_ack) begin
                    m_beats++; m_idles = 0;
                    if (m_beats == BL) m_owner = -1;
                end else if (!i_str_data_valid[m_owner]) begin
                    m_idles++;
                    if (m_idles == IM) m_owner = -1;
                end
            end
        end
    end

    // One clock of stimulus: observe handshakes before the edge, update sources/engine after it.
    task automatic step(input int p_src, input int p_eack, input int p_rack, input int p_rvld,
                        input bit hold1);
        logic [3:0]    fx;
        bit            ex;
        bit            rx;
        logic [DW+1:0] ent;
        logic [DW+1:0] e;
        @(negedge i_user_clk);
        fx  = i_str_data_valid & o_str_ack;
        ex  = o_eng_data_valid && i_eng_ack;
        ent = {o_eng_tag, o_eng_data ^ MASK};
        rx  = i_eng_res_valid && o_eng_res_ack;
        @(posedge i_user_clk);
        #1;
        if (rx) begin
            void'(eng_pipe.pop_front());
            res_hold = 1'b0;
        end
        if (ex) eng_pipe.push_back(ent);
        for (int k = 0; k < 4; k++) begin
            if (fx[k]) begin
                vld[k] = 1'b0;
                ph_x++;
            end
            if (!vld[k] && rem[k] > 0 && $urandom_range(99) < p_src) begin
                sdat[k] = {$urandom, $urandom};
                sdat[k][63:62] = 2'(k);
                vld[k] = 1'b1;
                rem[k]--;
                exp_fwd[k].push_back(sdat[k]);
                exp_ret[k].push_back(sdat[k] ^ MASK);
            end
            i_str_data[k*DW +: DW] = sdat[k];
            i_str_ack[k] = $urandom_range(99) < p_rack;
        end
        i_str_data_valid = vld;
        i_eng_ack = $urandom_range(99) < p_eack;
        if (hold1) i_str_ack[1] = 1'b0;
        if (!res_hold && eng_pipe.size() > 0 && $urandom_range(99) < p_rvld) res_hold = 1'b1;
        i_eng_res_valid = res_hold;
        if (eng_pipe.size() > 0) begin
            e = eng_pipe[0];
            i_eng_res_tag  = e[DW+1:DW];
            i_eng_res_data = e[DW-1:0];
        end
    endtask

    task automatic apply_reset();
        i_rst = 1'b0;
        vld = 4'h0;
        i_str_data_valid = 4'h0;
        i_eng_ack = 1'b0;
        i_str_ack = 4'h0;
        i_eng_res_valid = 1'b0;
        res_hold = 1'b0;
        @(posedge i_user_clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_fwd[k].delete();
            exp_ret[k].delete();
            rem[k] = 0;
        end
        eng_pipe.delete();
        @(negedge i_user_clk);
        chk("rst_busy", 64'(o_busy), 64'h0);
        chk("rst_grant", 64'(o_grant), 64'h0);
        chk("rst_str_ack", 64'(o_str_ack), 64'h0);
        chk("rst_eng_valid", 64'(o_eng_data_valid), 64'h0);
        chk("rst_ret_valid", 64'(o_str_data_valid), 64'h0);
        for (int k = 0; k < 4; k++) chk("rst_str_data", o_str_data[k*DW +: DW], 64'h0);
        @(posedge i_user_clk);
        #1;
        i_rst = 1'b1;
    endtask

    task automatic run_phase(input string name, input logic [3:0] en,
                             input int n0, input int n1, input int n2, input int n3,
                             input int p_src, input int p_eack, input int p_rack, input int p_rvld,
                             input int rst_at, input int hold_cyc);
        int cyc;
        bit done;
        apply_reset();
        i_chan_en = en;
        rem  = '{n0, n1, n2, n3};
        ph_x = 0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 6000) begin
            step(p_src, p_eack, p_rack, p_rvld, cyc < hold_cyc);
            cyc++;
            if (rst_at >= 0 && ph_x >= rst_at) begin
                apply_reset();
                done = 1'b1;
            end else begin
                done = (eng_pipe.size() == 0);
                for (int k = 0; k < 4; k++)
                    if (en[k] && (rem[k] > 0 || vld[k] || exp_fwd[k].size() > 0 ||
                                  exp_ret[k].size() > 0))
                        done = 1'b0;
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL timeout %s: got no drain after %0d cycles, want drained", name, cyc);
        end
    endtask

    initial begin
        i_rst = 1'b0;
        i_chan_en = 4'h0;
        i_str_data_valid = 4'h0;
        i_str_data = '0;
        i_eng_ack = 1'b0;
        i_eng_res_valid = 1'b0;
        i_eng_res_data = '0;
        i_eng_res_tag = 2'd0;
        i_str_ack = 4'h0;
        vld = 4'h0;
        res_hold = 1'b0;
        ph_x = 0;
        for (int k = 0; k < 4; k++) begin
            sdat[k] = '0;
            rem[k] = 0;
        end
        repeat (2) @(posedge i_user_clk);
        #1;
        mon_en = 1'b1;

        run_phase("single", 4'b0001, 40, 0, 0, 0, 100, 100, 100, 100, -1, 0);
        run_phase("fair", 4'b1111, 48, 48, 48, 48, 100, 100, 100, 100, -1, 0);
        run_phase("idle_drop", 4'b1100, 0, 0, 5, 20, 100, 100, 100, 100, -1, 0);
        run_phase("en_mask", 4'b1010, 20, 20, 20, 20, 100, 100, 100, 100, -1, 0);
        run_phase("ret_bp", 4'b0010, 0, 2, 0, 0, 100, 100, 100, 100, -1, 12);
        run_phase("rst_mid", 4'b0001, 30, 0, 0, 0, 100, 100, 100, 100, 7, 0);
        run_phase("after_rst", 4'b1111, 20, 20, 20, 20, 100, 100, 100, 100, -1, 0);
        for (int r = 0; r < 5; r++) begin
            run_phase("random", 4'($urandom_range(15, 1)),
                      int'($urandom_range(24)), int'($urandom_range(24)),
                      int'($urandom_range(24)), int'($urandom_range(24)),
                      int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                      int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
